physics_scheduler: RTL and testbench

- Per-frame sequencer for the rigid-body physics datapath.
- On each frame tick it walks every unordered body pair (i<j) through one shared collision-detect/resolve pipeline, a single time-multiplexed detector + resolver instance.
- It gates the resolved impulse into the selected pair's updaters, then pulses a global commit so all OBB registers load their next state together.
- Replaces the fixed two-body wiring and allows N bodies with one detector.

---
 rtl/physics_scheduler.sv | 146 ++++++++++++++
 tb/tb_physics_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/physics_scheduler.sv
// Per-frame pair sequencer: walks every body pair (i<j) through one shared
// collision detect/resolve pipeline, then pulses a global commit to all OBB registers.
module physics_scheduler #(
    parameter int N_OBJ   = 4,
    parameter int IDX_W   = $clog2(N_OBJ),
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic             res_valid,
    input  logic             is_collision,
    output logic [IDX_W-1:0] sel_a,
    output logic [IDX_W-1:0] sel_b,
    output logic             pair_start,
    output logic             impulse_we,
    output logic [N_OBJ-1:0] load_en,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] last_count,
    output logic             frame_overrun,
    output logic             timeout_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_B    = IDX_W'(N_OBJ - 1);
    localparam logic [IDX_W-1:0]  LAST_A    = IDX_W'(N_OBJ - 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_APPLY,
        S_COMMIT
    } state_t;

    state_t            state, state_nx;
    logic              prev_tick;
    logic              tick_edge;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              coll_q, coll_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic [CNT_W-1:0]  last_count_nx;
    logic [IDX_W-1:0]  sel_a_nx, sel_b_nx;
    logic              timeout_nx;

    assign tick_edge = frame_tick & ~prev_tick;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            prev_tick     <= 1'b0;
            wait_cnt      <= '0;
            coll_q        <= 1'b0;
            count         <= '0;
            last_count    <= '0;
            sel_a         <= '0;
            sel_b         <= '0;
            timeout_err   <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_nx;
            prev_tick     <= frame_tick;
            wait_cnt      <= wait_cnt_nx;
            coll_q        <= coll_nx;
            count         <= count_nx;
            last_count    <= last_count_nx;
            sel_a         <= sel_a_nx;
            sel_b         <= sel_b_nx;
            timeout_err   <= timeout_nx;
            // Any tick edge outside IDLE (COMMIT included) is dropped and flagged.
            frame_overrun <= tick_edge && (state != S_IDLE);
        end
    end

    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        coll_nx       = coll_q;
        count_nx      = count;
        last_count_nx = last_count;
        sel_a_nx      = sel_a;
        sel_b_nx      = sel_b;
        timeout_nx    = timeout_err;
        pair_start    = 1'b0;
        impulse_we    = 1'b0;
        load_en       = '0;
        frame_done    = 1'b0;

        case (state)
            S_IDLE: begin
                if (tick_edge && enable) begin
                    state_nx = S_ISSUE;
                    sel_a_nx = '0;
                    sel_b_nx = IDX_W'(1);
                    count_nx = '0;
                end
            end
            S_ISSUE: begin
                pair_start  = 1'b1;
                wait_cnt_nx = '0;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_nx = wait_cnt + WAIT_W'(1);
                if (res_valid) begin
                    coll_nx  = is_collision;
                    state_nx = S_APPLY;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Pipeline never answered: abandon the pair as a non-collision.
                    coll_nx    = 1'b0;
                    timeout_nx = 1'b1;
                    state_nx   = S_APPLY;
                end
            end
            S_APPLY: begin
                impulse_we = coll_q;
                if (coll_q && (count != '1)) begin
                    count_nx = count + CNT_W'(1);
                end
                if (sel_b < LAST_B) begin
                    sel_b_nx = sel_b + IDX_W'(1);
                    state_nx = S_ISSUE;
                end else if (sel_a < LAST_A) begin
                    sel_a_nx = sel_a + IDX_W'(1);
                    sel_b_nx = sel_a + IDX_W'(2);
                    state_nx = S_ISSUE;
                end else begin
                    state_nx = S_COMMIT;
                end
            end
            S_COMMIT: begin
                load_en       = '1;
                frame_done    = 1'b1;
                last_count_nx = count;
                state_nx      = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_physics_scheduler.sv
// Self-checking bench for physics_scheduler: each frame is planned as a
// per-cycle expected trace built from the pair list and pipeline latencies.
module tb_physics_scheduler;

    localparam int N_OBJ   = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             frame_tick = 1'b0;
    logic             enable = 1'b0;
    logic             res_valid = 1'b0;
    logic             is_collision = 1'b0;
    logic [IDX_W-1:0] sel_a, sel_b;
    logic             pair_start, impulse_we, busy, frame_done;
    logic [N_OBJ-1:0] load_en;
    logic [CNT_W-1:0] last_count;
    logic             frame_overrun, timeout_err;

    physics_scheduler #(.N_OBJ(N_OBJ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .enable(enable),
        .res_valid(res_valid), .is_collision(is_collision),
        .sel_a(sel_a), .sel_b(sel_b), .pair_start(pair_start), .impulse_we(impulse_we),
        .load_en(load_en), .busy(busy), .frame_done(frame_done), .last_count(last_count),
        .frame_overrun(frame_overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Planned per-cycle inputs and expected outputs for one frame.
    bit tick_q[$], en_q[$], rv_q[$], ic_q[$];
    bit ps_q[$], iw_q[$], dn_q[$], bz_q[$], te_q[$];
    int sa_q[$], sb_q[$];
    bit te_model = 1'b0;
    int plan_count;
    int last_model = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pushCycle(input bit t, input bit e, input bit rv, input bit ic, input bit ps,
                             input bit iw, input bit dn, input bit bz, input int sa, input int sb);
        tick_q.push_back(t); en_q.push_back(e); rv_q.push_back(rv); ic_q.push_back(ic);
        ps_q.push_back(ps); iw_q.push_back(iw); dn_q.push_back(dn); bz_q.push_back(bz);
        te_q.push_back(te_model); sa_q.push_back(sa); sb_q.push_back(sb);
    endtask

    // mode 0 random, 1 basic (L=2, overrun at +10, enable drop at +5),
    // 2 collisions on (0,2),(2,3), 3 timeout on pair (1,2).
    task automatic planFrame(input int mode);
        int h, k, commit_idx, lat, nw;
        bit resp, coll, rv;
        tick_q.delete(); en_q.delete(); rv_q.delete(); ic_q.delete();
        ps_q.delete(); iw_q.delete(); dn_q.delete(); bz_q.delete(); te_q.delete();
        sa_q.delete(); sb_q.delete();
        plan_count = 0;
        pushCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < N_OBJ; i++) begin
            for (int j = i + 1; j < N_OBJ; j++) begin
                resp = 1'b1; lat = 2; coll = 1'b0;
                case (mode)
                    0: begin
                        resp = ($urandom_range(0, 7) != 0);
                        lat  = $urandom_range(1, 5);
                        coll = 1'($urandom_range(0, 1));
                    end
                    2: coll = (i == 0 && j == 2) || (i == 2 && j == 3);
                    3: resp = !(i == 1 && j == 2);
                    default: ;
                endcase
                pushCycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, i, j);
                nw = resp ? lat : TIMEOUT;
                for (int w = 1; w <= nw; w++) begin
                    rv = resp && (w == lat);
                    pushCycle(1'b0, 1'($urandom), rv, rv ? coll : 1'($urandom),
                              1'b0, 1'b0, 1'b0, 1'b1, i, j);
                end
                if (!resp) te_model = 1'b1;
                pushCycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                          1'b0, resp && coll, 1'b0, 1'b1, i, j);
                if (resp && coll && plan_count < 255) plan_count++;
            end
        end
        pushCycle(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        commit_idx = tick_q.size() - 1;
        pushCycle(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        pushCycle(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        h = (mode == 0) ? $urandom_range(1, 3) : 1;
        for (int c = 0; c < h; c++) tick_q[c] = 1'b1;
        if (mode == 1) begin
            tick_q[10] = 1'b1;
            tick_q[11] = 1'b1;
            for (int c = 5; c < tick_q.size(); c++) en_q[c] = 1'b0;
        end else if (mode == 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(h + 1, commit_idx);
            tick_q[k] = 1'b1;
        end
    endtask

    // Runs the first ncyc planned cycles; full runs also check last_count.
    task automatic applyStimulus(input int ncyc, input bit full);
        logic [31:0] got, exp;
        bit exp_ov;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            frame_tick   = tick_q[c];
            enable       = en_q[c];
            res_valid    = rv_q[c];
            is_collision = ic_q[c];
            @(negedge clk);
            exp_ov = (c >= 1) && tick_q[c-1] && !((c >= 2) && tick_q[c-2]) && bz_q[c-1];
            got = {22'b0, pair_start, impulse_we, frame_done, busy, frame_overrun, timeout_err, load_en};
            exp = {22'b0, ps_q[c], iw_q[c], dn_q[c], bz_q[c], exp_ov, te_q[c], dn_q[c] ? 4'hF : 4'h0};
            checkOutput($sformatf("ctl c%0d", c), got, exp);
            if (sa_q[c] >= 0)
                checkOutput($sformatf("sel c%0d", c), {28'b0, sel_a, sel_b},
                            {28'b0, IDX_W'(sa_q[c]), IDX_W'(sb_q[c])});
        end
        if (full) begin
            last_model = plan_count;
            checkOutput("last_count", 32'(last_count), 32'(last_model));
        end
    endtask

    task automatic idleEdgeNoEnable();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            frame_tick = (c < 2);
            enable     = 1'b0;
            res_valid  = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("noen c%0d", c), {29'b0, pair_start, busy, frame_overrun}, 32'h0);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {10'b0, pair_start, impulse_we, frame_done, busy, frame_overrun,
                          timeout_err, load_en, sel_a, sel_b, last_count}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        planFrame(1); applyStimulus(tick_q.size(), 1'b1);
        idleEdgeNoEnable();
        planFrame(2); applyStimulus(tick_q.size(), 1'b1);
        planFrame(3); applyStimulus(tick_q.size(), 1'b1);
        for (int f = 0; f < 8; f++) begin
            planFrame(0); applyStimulus(tick_q.size(), 1'b1);
        end

        // Reset during pair (1,2) of a basic frame.
        planFrame(1); applyStimulus(15, 1'b0);
        #1 reset_n = 1'b0;
        #1 checkResetOutputs("reset async");
        frame_tick = 1'b0; enable = 1'b0; res_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset hold");
        reset_n = 1'b1;
        te_model = 1'b0;
        last_model = 0;
        @(negedge clk);
        checkOutput("post reset busy", {31'b0, busy}, 32'h0);

        for (int f = 0; f < 3; f++) begin
            planFrame(0); applyStimulus(tick_q.size(), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
